fadd_sched: RTL and testbench

// - Shares one multi-cycle single-precision FP adder core (compare/align/add/normalize) among NREQ requesters.
// - Round-robin arbitration, one operation in flight, watchdog on the core, per-requester response handshake.
// - Sits between client units and the adder core; the core's internals are unchanged.

---
 rtl/fpu_pkg.sv | 12 +
 rtl/fadd_sched_if.sv | 30 +++
 rtl/rr_arbiter.sv | 28 ++
 rtl/fadd_sched.sv | 106 ++++++++++
 tb/tb_fadd_sched.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FP constants and scheduler state encoding for the shared adder front-end.
package fpu_pkg;
   localparam int          FP_W    = 32;
   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;
endpackage

// File: rtl/fadd_sched_if.sv
// Requester, core and response signals of the shared FP adder scheduler.
interface fadd_sched_if #(
   parameter int NREQ = 4,
   parameter int CNTW = 16
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [32*NREQ-1:0] req_a;
   logic [32*NREQ-1:0] req_b;
   logic               core_start;
   logic [31:0]        core_a;
   logic [31:0]        core_b;
   logic               core_done;
   logic [31:0]        core_res;
   logic [NREQ-1:0]    resp_valid;
   logic [NREQ-1:0]    resp_ready;
   logic [31:0]        resp_data;
   logic               resp_err;
   logic [CNTW-1:0]    op_count;

   modport master (
      output req_valid, req_a, req_b, core_done, core_res, resp_ready,
      input  req_ready, core_start, core_a, core_b, resp_valid, resp_data, resp_err, op_count
   );

   modport slave (
      input  req_valid, req_a, req_b, core_done, core_res, resp_ready,
      output req_ready, core_start, core_a, core_b, resp_valid, resp_data, resp_err, op_count
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping mod NREQ.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic [NREQ-1:0] grant,
   output logic [IDXW-1:0] idx,
   output logic            any
);
   logic [IDXW-1:0] j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = '0;
      for (int k = 1; k <= NREQ; k++) begin
         j = IDXW'((int'(ptr) + k) % NREQ);
         if (!any && req[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = j;
         end
      end
   end
endmodule

// File: rtl/fadd_sched.sv
// Shares one multi-cycle FP adder among NREQ requesters, one operation in flight.
//  state   | meaning
//  S_IDLE  | arbitrate, accept one request and latch its operands
//  S_ISSUE | pulse core_start, clear watchdog
//  S_WAIT  | wait for core_done or watchdog expiry
//  S_RESP  | hold response for the owning requester until it is consumed
module fadd_sched
   import fpu_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64,
   parameter int CNTW    = 16
) (
   input  logic        clk,
   input  logic        rst,
   fadd_sched_if.slave bus
);
   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW   = $clog2(TIMEOUT + 1);

   state_t          state, state_nx;
   logic [IDXW-1:0] rr_ptr;
   logic [IDXW-1:0] id;
   logic [TW-1:0]   timer;
   logic [NREQ-1:0] grant;
   logic [IDXW-1:0] gidx;
   logic            gany;
   logic            timeout;
   logic            resp_hs;

   rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_arb (
      .req   (bus.req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (gidx),
      .any   (gany)
   );

   assign timeout = (timer == TW'(TIMEOUT - 1));
   assign resp_hs = bus.resp_ready[id];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (gany) state_nx = S_ISSUE;
         S_ISSUE: state_nx = S_WAIT;
         S_WAIT:  if (bus.core_done || timeout) state_nx = S_RESP;
         S_RESP:  if (resp_hs) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // req_ready is gated by rst so it reads zero while reset is held.
   always_comb begin
      bus.req_ready  = (!rst && state == S_IDLE) ? grant : '0;
      bus.core_start = (state == S_ISSUE);
      bus.resp_valid = (state == S_RESP) ? (NREQ'(1) << id) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr        <= IDXW'(NREQ - 1);
         id            <= '0;
         timer         <= '0;
         bus.core_a    <= '0;
         bus.core_b    <= '0;
         bus.resp_data <= '0;
         bus.resp_err  <= 1'b0;
         bus.op_count  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (gany) begin
                  bus.core_a <= bus.req_a[int'(gidx)*FP_W +: FP_W];
                  bus.core_b <= bus.req_b[int'(gidx)*FP_W +: FP_W];
                  id         <= gidx;
               end
            end
            S_ISSUE: timer <= '0;
            S_WAIT: begin
               timer <= timer + 1'b1;
               // A result arriving on the final watchdog cycle still wins.
               if (bus.core_done) begin
                  bus.resp_data <= bus.core_res;
                  bus.resp_err  <= 1'b0;
               end else if (timeout) begin
                  bus.resp_data <= FP_QNAN;
                  bus.resp_err  <= 1'b1;
               end
            end
            S_RESP: begin
               if (resp_hs) begin
                  rr_ptr       <= id;
                  bus.op_count <= bus.op_count + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_fadd_sched.sv
// Directed bench for fadd_sched: single op, round robin, watchdog, stall and reset abort.
module tb_fadd_sched;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 16;
   localparam int CNTW    = 16;

   logic clk;
   logic rst;
   int   vec_cnt;
   int   err_cnt;
   int   exp_cnt;

   fadd_sched_if #(.NREQ(NREQ), .CNTW(CNTW)) bif ();

   fadd_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b);
      bif.req_a[32*r +: 32] = a;
      bif.req_b[32*r +: 32] = b;
      bif.req_valid[r]      = 1'b1;
   endtask

   // Waits (bounded) for a grant, checks it, then passes the accept edge.
   task automatic accept(input int r, input bit keep);
      #1;
      for (int i = 0; i < 20 && bif.req_ready == '0; i++) tick();
      chk("grant", 64'(bif.req_ready), 64'(NREQ'(1) << r));
      tick();
      if (!keep) bif.req_valid[r] = 1'b0;
      chk("core_start", 64'(bif.core_start), 64'd1);
      chk("ready_busy", 64'(bif.req_ready), 64'd0);
   endtask

   // Called in the ISSUE cycle; core_done arrives k cycles later.
   task automatic core_reply(input int k, input logic [31:0] res);
      repeat (k) tick();
      bif.core_done = 1'b1;
      bif.core_res  = res;
      tick();
      bif.core_done = 1'b0;
      bif.core_res  = 32'h0;
   endtask

   task automatic respond(input int r, input logic [31:0] d, input logic e);
      chk("resp_valid", 64'(bif.resp_valid), 64'(NREQ'(1) << r));
      chk("resp_data", 64'(bif.resp_data), 64'(d));
      chk("resp_err", 64'(bif.resp_err), 64'(e));
      bif.resp_ready[r] = 1'b1;
      tick();
      bif.resp_ready[r] = 1'b0;
      exp_cnt++;
      chk("op_count", 64'(bif.op_count), 64'(exp_cnt));
      chk("resp_drop", 64'(bif.resp_valid), 64'd0);
   endtask

   initial begin
      int ord[5];
      vec_cnt = 0;
      err_cnt = 0;
      exp_cnt = 0;
      rst            = 1'b1;
      bif.req_valid  = '0;
      bif.req_a      = '0;
      bif.req_b      = '0;
      bif.core_done  = 1'b0;
      bif.core_res   = '0;
      bif.resp_ready = '0;
      repeat (2) tick();

      chk("rst_ready", 64'(bif.req_ready), 64'd0);
      chk("rst_rvalid", 64'(bif.resp_valid), 64'd0);
      chk("rst_start", 64'(bif.core_start), 64'd0);
      chk("rst_err", 64'(bif.resp_err), 64'd0);
      chk("rst_data", 64'(bif.resp_data), 64'd0);
      chk("rst_cnt", 64'(bif.op_count), 64'd0);
      chk("rst_core_a", 64'(bif.core_a), 64'd0);
      rst = 1'b0;
      tick();

      // Single operation, done 2 cycles after start.
      set_req(0, 32'h3F80_0000, 32'h4000_0000);
      accept(0, 1'b0);
      chk("core_a", 64'(bif.core_a), 64'h3F80_0000);
      chk("core_b", 64'(bif.core_b), 64'h4000_0000);
      core_reply(2, 32'h4040_0000);
      respond(0, 32'h4040_0000, 1'b0);

      // Fresh reset, then everyone requests continuously.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_cnt = 0;
      ord = '{0, 1, 2, 3, 0};
      for (int r = 0; r < NREQ; r++) set_req(r, 32'h4100_0000 + 32'(r), 32'h3F80_0000);
      for (int i = 0; i < 5; i++) begin
         accept(ord[i], 1'b1);
         core_reply(1, 32'h4080_0000 + 32'(i));
         chk("rr_noready", 64'(bif.req_ready), 64'd0);
         respond(ord[i], 32'h4080_0000 + 32'(i), 1'b0);
      end
      bif.req_valid = '0;

      // Watchdog: core never answers.
      set_req(2, 32'h4000_0000, 32'h4000_0000);
      accept(2, 1'b0);
      repeat (TIMEOUT) tick();
      chk("to_early", 64'(bif.resp_valid), 64'd0);
      tick();
      respond(2, 32'h7FC0_0000, 1'b1);

      // core_done on the final WAIT cycle wins over the timeout.
      set_req(3, 32'h4000_0000, 32'h4100_0000);
      accept(3, 1'b0);
      repeat (TIMEOUT - 1) tick();
      chk("last_early", 64'(bif.resp_valid), 64'd0);
      core_reply(1, 32'h4120_0000);
      respond(3, 32'h4120_0000, 1'b0);

      // Stalled response: stable outputs, foreign resp_ready ignored, no new grant.
      set_req(1, 32'h3F00_0000, 32'h3F00_0000);
      accept(1, 1'b0);
      core_reply(1, 32'h3F80_0000);
      set_req(0, 32'h1111_1111, 32'h2222_2222);
      bif.resp_ready = 4'b1101;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall_valid", 64'(bif.resp_valid), 64'h2);
         chk("stall_data", 64'(bif.resp_data), 64'h3F80_0000);
         chk("stall_ready", 64'(bif.req_ready), 64'd0);
      end
      bif.resp_ready = '0;
      respond(1, 32'h3F80_0000, 1'b0);
      chk("after_hs_grant", 64'(bif.req_ready), 64'h1);
      bif.req_valid = '0;

      // Reset during WAIT aborts; late core_done is ignored.
      set_req(1, 32'h4040_0000, 32'h4040_0000);
      accept(1, 1'b1);
      tick();
      rst = 1'b1;
      #1;
      chk("arst_core_a", 64'(bif.core_a), 64'd0);
      chk("arst_cnt", 64'(bif.op_count), 64'd0);
      chk("arst_ready", 64'(bif.req_ready), 64'd0);
      chk("arst_rvalid", 64'(bif.resp_valid), 64'd0);
      chk("arst_start", 64'(bif.core_start), 64'd0);
      tick();
      bif.req_valid = '0;
      rst = 1'b0;
      bif.core_done = 1'b1;
      bif.core_res  = 32'hDEAD_BEEF;
      tick();
      bif.core_done = 1'b0;
      tick();
      chk("late_done_valid", 64'(bif.resp_valid), 64'd0);
      chk("late_done_data", 64'(bif.resp_data), 64'd0);
      bif.req_valid = 4'hF;
      #1;
      chk("post_rst_grant", 64'(bif.req_ready), 64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
